mem_port_arbiter: RTL and testbench

//   Shares the single main-memory block port between two direct-mapped cache controllers
//   (port 0 = instruction cache, port 1 = data cache; same mem-side protocol as dm_cache_fsm).

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory block port between an instruction cache (port 0)
// and a data cache (port 1). One outstanding transaction; a watchdog aborts stalled ones.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned BLK_W   = 128,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c0_req_valid,
   input  logic              c0_req_rw,
   input  logic [ADDR_W-1:0] c0_req_addr,
   input  logic [BLK_W-1:0]  c0_req_data,
   output logic              c0_data_ready,
   input  logic              c1_req_valid,
   input  logic              c1_req_rw,
   input  logic [ADDR_W-1:0] c1_req_addr,
   input  logic [BLK_W-1:0]  c1_req_data,
   output logic              c1_data_ready,
   output logic [BLK_W-1:0]  cx_data_data,
   output logic              mem_req_valid,
   output logic              mem_req_rw,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [BLK_W-1:0]  mem_req_data,
   input  logic              mem_data_ready,
   input  logic [BLK_W-1:0]  mem_data_data,
   output logic              timeout_err,
   output logic              err_port
);

   typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

   localparam bit          WdogEn  = (TIMEOUT != 0);
   localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

   state_e              state_q, state_d;
   logic                req_valid_q, req_valid_d;
   logic                req_rw_q, req_rw_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic [BLK_W-1:0]    req_data_q, req_data_d;
   logic                timeout_err_q, timeout_err_d;
   logic                err_port_q, err_port_d;
   logic                last_grant_q, last_grant_d;
   logic                grant_q, grant_d;
   logic [15:0]         cnt_q, cnt_d;
   logic                grant_sel;
   logic                busy_done;

   // Lone requester wins outright; on a tie the port not granted last time wins.
   assign grant_sel = c1_req_valid & (~c0_req_valid | ~last_grant_q);

   always_comb begin
      state_d       = state_q;
      req_valid_d   = req_valid_q;
      req_rw_d      = req_rw_q;
      req_addr_d    = req_addr_q;
      req_data_d    = req_data_q;
      timeout_err_d = 1'b0;
      err_port_d    = err_port_q;
      last_grant_d  = last_grant_q;
      grant_d       = grant_q;
      cnt_d         = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (c0_req_valid || c1_req_valid) begin
               grant_d      = grant_sel;
               last_grant_d = grant_sel;
               req_rw_d     = grant_sel ? c1_req_rw   : c0_req_rw;
               req_addr_d   = grant_sel ? c1_req_addr : c0_req_addr;
               req_data_d   = grant_sel ? c1_req_data : c0_req_data;
               req_valid_d  = 1'b1;
               cnt_d        = 16'd0;
               state_d      = StBusy;
            end
         end
         StBusy: begin
            if (mem_data_ready) begin
               req_valid_d = 1'b0;
               state_d     = StRelease;
            end else if (WdogEn && (cnt_q == CntLast)) begin
               req_valid_d   = 1'b0;
               timeout_err_d = 1'b1;
               err_port_d    = grant_q;
               state_d       = StRelease;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StRelease: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         req_valid_q   <= 1'b0;
         req_rw_q      <= 1'b0;
         req_addr_q    <= '0;
         req_data_q    <= '0;
         timeout_err_q <= 1'b0;
         err_port_q    <= 1'b0;
         last_grant_q  <= 1'b1;
         grant_q       <= 1'b0;
         cnt_q         <= 16'd0;
      end else begin
         state_q       <= state_d;
         req_valid_q   <= req_valid_d;
         req_rw_q      <= req_rw_d;
         req_addr_q    <= req_addr_d;
         req_data_q    <= req_data_d;
         timeout_err_q <= timeout_err_d;
         err_port_q    <= err_port_d;
         last_grant_q  <= last_grant_d;
         grant_q       <= grant_d;
         cnt_q         <= cnt_d;
      end
   end

   // Completion is combinational; a reset in the same cycle suppresses it.
   assign busy_done     = (state_q == StBusy) & mem_data_ready & ~rst;
   assign c0_data_ready = busy_done & ~grant_q;
   assign c1_data_ready = busy_done & grant_q;
   assign cx_data_data  = mem_data_data;

   assign mem_req_valid = req_valid_q;
   assign mem_req_rw    = req_rw_q;
   assign mem_req_addr  = req_addr_q;
   assign mem_req_data  = req_data_q;
   assign timeout_err   = timeout_err_q;
   assign err_port      = err_port_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester queues per port, a latency-programmable
// memory model, and an expected-transaction queue checked on every completion or abort.
module tb_mem_port_arbiter;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned BLK_W   = 128;
   localparam int unsigned TIMEOUT = 8;
   localparam logic [31:0] DeadAddr = 32'hDEAD_0000;

   typedef struct {
      logic         rw;
      logic [31:0]  addr;
      logic [127:0] data;
   } req_t;

   typedef struct {
      logic         port;
      logic         to;
      logic [31:0]  addr;
      logic         rw;
      logic [127:0] wdata;
      logic [127:0] rdata;
      int           busy;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              c0_req_valid, c0_req_rw, c0_data_ready;
   logic [ADDR_W-1:0] c0_req_addr;
   logic [BLK_W-1:0]  c0_req_data;
   logic              c1_req_valid, c1_req_rw, c1_data_ready;
   logic [ADDR_W-1:0] c1_req_addr;
   logic [BLK_W-1:0]  c1_req_data;
   logic [BLK_W-1:0]  cx_data_data;
   logic              mem_req_valid, mem_req_rw;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [BLK_W-1:0]  mem_req_data;
   logic              mem_data_ready;
   logic [BLK_W-1:0]  mem_data_data;
   logic              timeout_err, err_port;

   req_t rq0[$];
   req_t rq1[$];
   exp_t sb[$];

   int           n_checks = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           run = 0;
   int           last_run = 0;
   int           last_done = -1;
   int           exp_gap = 0;
   int           mem_lat = -1;
   bit           mem_tie = 1'b0;
   logic [127:0] mem_rdata = '0;
   int           busy_cyc = 0;

   localparam logic [127:0] Pattern = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;

   mem_port_arbiter #(
      .ADDR_W (ADDR_W),
      .BLK_W  (BLK_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .c0_req_valid  (c0_req_valid),
      .c0_req_rw     (c0_req_rw),
      .c0_req_addr   (c0_req_addr),
      .c0_req_data   (c0_req_data),
      .c0_data_ready (c0_data_ready),
      .c1_req_valid  (c1_req_valid),
      .c1_req_rw     (c1_req_rw),
      .c1_req_addr   (c1_req_addr),
      .c1_req_data   (c1_req_data),
      .c1_data_ready (c1_data_ready),
      .cx_data_data  (cx_data_data),
      .mem_req_valid (mem_req_valid),
      .mem_req_rw    (mem_req_rw),
      .mem_req_addr  (mem_req_addr),
      .mem_req_data  (mem_req_data),
      .mem_data_ready(mem_data_ready),
      .mem_data_data (mem_data_data),
      .timeout_err   (timeout_err),
      .err_port      (err_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory answers mem_lat cycles into a request; DeadAddr is never answered.
   always @(posedge clk) begin
      if (mem_req_valid && !mem_data_ready) busy_cyc <= busy_cyc + 1;
      else busy_cyc <= 0;
   end
   assign mem_data_ready = mem_tie || (mem_req_valid && mem_lat >= 0 && busy_cyc == mem_lat &&
                                       mem_req_addr != DeadAddr);
   assign mem_data_data  = mem_rdata;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic add_txn(input bit port, input logic rw, input logic [31:0] addr,
                          input logic [127:0] wdata, input int busy, input bit to);
      req_t r;
      exp_t e;
      r.rw = rw; r.addr = addr; r.data = wdata;
      if (port) rq1.push_back(r);
      else rq0.push_back(r);
      e.port = port; e.to = to; e.addr = addr; e.rw = rw; e.wdata = wdata;
      e.rdata = mem_rdata; e.busy = busy;
      sb.push_back(e);
   endtask

   task automatic present(input bit port);
      req_t r;
      if (!port && !c0_req_valid && rq0.size() > 0) begin
         r = rq0.pop_front();
         c0_req_rw = r.rw; c0_req_addr = r.addr; c0_req_data = r.data; c0_req_valid = 1'b1;
      end
      if (port && !c1_req_valid && rq1.size() > 0) begin
         r = rq1.pop_front();
         c1_req_rw = r.rw; c1_req_addr = r.addr; c1_req_data = r.data; c1_req_valid = 1'b1;
      end
   endtask

   task automatic mon_step();
      exp_t e;
      cyc++;
      if (mem_req_valid) run++;
      else begin
         if (run != 0) last_run = run;
         run = 0;
      end
      if (mem_req_valid) begin
         if (sb.size() == 0) check("req_without_txn", 128'(mem_req_valid), 128'(0));
         else begin
            check("mem_req_addr", 128'(mem_req_addr), 128'(sb[0].addr));
            check("mem_req_rw", 128'(mem_req_rw), 128'(sb[0].rw));
            check("mem_req_data", mem_req_data, sb[0].wdata);
         end
      end
      if (c0_data_ready || c1_data_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_ready", 128'({c1_data_ready, c0_data_ready}), 128'(0));
         end else begin
            e = sb.pop_front();
            check("ready_port", 128'({c1_data_ready, c0_data_ready}),
                  e.to ? 128'(0) : (e.port ? 128'(2) : 128'(1)));
            check("cx_data_data", cx_data_data, e.rdata);
            check("busy_len", 128'(run), 128'(e.busy));
            if (exp_gap != 0 && last_done >= 0)
               check("completion_gap", 128'(cyc - last_done), 128'(exp_gap));
            last_done = cyc;
            if (c0_data_ready) c0_req_valid = 1'b0;
            if (c1_data_ready) c1_req_valid = 1'b0;
         end
      end
      if (timeout_err) begin
         if (sb.size() == 0) begin
            check("unexpected_timeout", 128'(timeout_err), 128'(0));
         end else begin
            e = sb.pop_front();
            check("timeout_expected", 128'(timeout_err), 128'(e.to));
            check("err_port", 128'(err_port), 128'(e.port));
            check("timeout_len", 128'(last_run), 128'(e.busy));
            if (e.port) c1_req_valid = 1'b0;
            else c0_req_valid = 1'b0;
         end
      end
      present(1'b0);
      present(1'b1);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         mon_step();
      end
   end

   task automatic wait_drain(input int max);
      int i = 0;
      while ((sb.size() != 0 || c0_req_valid || c1_req_valid) && i < max) begin
         @(posedge clk); #1;
         i++;
      end
      check("drain_pending", 128'(sb.size()), 128'(0));
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int max);
      int i = 0;
      while (!mem_req_valid && i < max) begin
         @(posedge clk); #1;
         i++;
      end
      check("wait_mem_req_valid", 128'(mem_req_valid), 128'(1));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      c0_req_valid = 1'b0;
      c1_req_valid = 1'b0;
      rq0.delete();
      rq1.delete();
      repeat (2) @(posedge clk);
      #1;
      sb.delete();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      c0_req_valid = 1'b0; c0_req_rw = 1'b0; c0_req_addr = '0; c0_req_data = '0;
      c1_req_valid = 1'b0; c1_req_rw = 1'b0; c1_req_addr = '0; c1_req_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_req_valid", 128'(mem_req_valid), 128'(0));
      check("rst_mem_req_rw", 128'(mem_req_rw), 128'(0));
      check("rst_mem_req_addr", 128'(mem_req_addr), 128'(0));
      check("rst_mem_req_data", mem_req_data, 128'(0));
      check("rst_timeout_err", 128'(timeout_err), 128'(0));
      check("rst_err_port", 128'(err_port), 128'(0));
      check("rst_data_ready", 128'({c1_data_ready, c0_data_ready}), 128'(0));
      rst = 1'b0;

      // Single read on port 0, memory answers in the 4th busy cycle.
      mem_lat = 3; mem_rdata = 128'd59;
      add_txn(1'b0, 1'b0, 32'h120, '0, 4, 1'b0);
      wait_drain(50);

      // Simultaneous requests after reset: port 0 first, then alternation.
      do_reset();
      mem_lat = 2; mem_rdata = 128'h1111_2222;
      add_txn(1'b0, 1'b0, 32'h200, {4{32'h200}}, 3, 1'b0);
      add_txn(1'b1, 1'b0, 32'h210, {4{32'h210}}, 3, 1'b0);
      add_txn(1'b0, 1'b1, 32'h220, {4{32'h220}}, 3, 1'b0);
      add_txn(1'b1, 1'b1, 32'h230, {4{32'h230}}, 3, 1'b0);
      wait_drain(100);

      // Port 1 write; request fields change mid-transaction and must not leak through.
      mem_lat = 4; mem_rdata = 128'h77;
      add_txn(1'b1, 1'b1, 32'h630, Pattern, 5, 1'b0);
      wait_valid(20);
      @(posedge clk); #1;
      c1_req_addr = 32'h999; c1_req_data = ~Pattern; c1_req_rw = 1'b0;
      wait_drain(50);

      // Memory never answers port 1: watchdog abort, then the waiting port 0 is served.
      mem_lat = 2; mem_rdata = 128'h4242;
      add_txn(1'b1, 1'b0, DeadAddr, '0, int'(TIMEOUT), 1'b1);
      wait_valid(20);
      add_txn(1'b0, 1'b0, 32'h240, {4{32'h5}}, 3, 1'b0);
      wait_drain(100);

      // Reset in the second busy cycle aborts silently and restores the tie-break.
      mem_lat = -1;
      add_txn(1'b0, 1'b0, 32'h300, '0, 0, 1'b0);
      wait_valid(20);
      @(posedge clk); #1;
      rst = 1'b1;
      c0_req_valid = 1'b0;
      rq0.delete();
      @(posedge clk); #1;
      check("abort_mem_req_valid", 128'(mem_req_valid), 128'(0));
      check("abort_timeout_err", 128'(timeout_err), 128'(0));
      check("abort_err_port", 128'(err_port), 128'(0));
      sb.delete();
      rst = 1'b0;
      mem_lat = 1; mem_rdata = 128'h5555;
      add_txn(1'b0, 1'b0, 32'h310, '0, 2, 1'b0);
      add_txn(1'b1, 1'b0, 32'h320, '0, 2, 1'b0);
      wait_drain(50);

      // Memory always ready, both ports saturated: 1-cycle busy, completion every 3 cycles.
      mem_lat = -1; mem_tie = 1'b1; mem_rdata = 128'hABCD;
      exp_gap = 3; last_done = -1;
      for (int i = 0; i < 3; i++) begin
         add_txn(1'b0, 1'b0, 32'h400 + 32'(i * 16), '0, 1, 1'b0);
         add_txn(1'b1, 1'b1, 32'h800 + 32'(i * 16), {4{32'(i)}}, 1, 1'b0);
      end
      wait_drain(100);
      exp_gap = 0;
      mem_tie = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
